weight_ram_arbiter: RTL and testbench

- Shares the single-port weight block RAM (1-cycle registered read) between two requesters.
  - RD port: the inference RAM read driver.
  - HOST port: the weight load/update path.
- Sits between those requesters and the RAM.
- Per-cycle round-robin arbitration, plus lock phases so a layer read or a multi-word weight update is never interleaved.
- Returns read data with a valid strobe, tagged to the owner that issued the read.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/weight_ram_rr_pick.sv | 35 +++
 rtl/weight_ram_arbiter.sv | 110 +++++++++++
 tb/tb_weight_ram_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared encodings and widths for the weight RAM, its read driver and the RAM mux.
package nn_pkg;

   localparam int WEIGHT_ADDR_W = 10;
   localparam int WEIGHT_DATA_W = 8;

   typedef enum logic [1:0] {
      OWN_IDLE      = 2'd0,
      OWN_RD_LOCK   = 2'd1,
      OWN_HOST_LOCK = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      RTAG_NONE = 2'd0,
      RTAG_RD   = 2'd1,
      RTAG_HOST = 2'd2
   } rtag_e;

   typedef enum logic {
      PORT_RD   = 1'b0,
      PORT_HOST = 1'b1
   } port_e;

endpackage

// File: rtl/weight_ram_rr_pick.sv
// Combinational grant picker: round-robin in open arbitration, exclusive while a lock is held.
module weight_ram_rr_pick
   import nn_pkg::*;
(
   input  logic       i_en,
   input  logic       i_rd_req,
   input  logic       i_host_req,
   input  logic [1:0] i_state,
   input  logic       i_last_served,
   output logic       o_rd_gnt,
   output logic       o_host_gnt
);

   always_comb begin
      o_rd_gnt   = 1'b0;
      o_host_gnt = 1'b0;
      if (i_en) begin
         case (owner_e'(i_state))
            OWN_RD_LOCK:   o_rd_gnt   = i_rd_req;
            OWN_HOST_LOCK: o_host_gnt = i_host_req;
            default: begin
               // On a tie the port that did not win last time goes first.
               if (i_rd_req && i_host_req) begin
                  if (i_last_served == PORT_HOST) o_rd_gnt   = 1'b1;
                  else                            o_host_gnt = 1'b1;
               end else begin
                  o_rd_gnt   = i_rd_req;
                  o_host_gnt = i_host_req;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/weight_ram_arbiter.sv
// Shares the single-port weight RAM between the inference read driver and the host
// update path, with lock phases and owner-tagged read return.
module weight_ram_arbiter
   import nn_pkg::*;
#(
   parameter int ADDR_W  = WEIGHT_ADDR_W,
   parameter int DATA_W  = WEIGHT_DATA_W,
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rd_req,
   input  logic               rd_lock,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic               rd_gnt,
   output logic               rd_valid,
   output logic [DATA_W-1:0]  rd_data,
   input  logic               host_req,
   input  logic               host_lock,
   input  logic               host_we,
   input  logic [ADDR_W-1:0]  host_addr,
   input  logic [DATA_W-1:0]  host_wdata,
   output logic               host_gnt,
   output logic               host_rvalid,
   output logic [DATA_W-1:0]  host_rdata,
   output logic               ram_en,
   output logic               ram_we,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [DATA_W-1:0]  ram_din,
   input  logic [DATA_W-1:0]  ram_dout,
   output logic [1:0]         owner,
   output logic [STALL_W-1:0] rd_stall_cnt
);

   localparam logic [STALL_W-1:0] STALL_MAX = '1;
   localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

   owner_e             r_state;
   owner_e             w_state_eff;
   owner_e             w_state_nxt;
   rtag_e              r_rtag;
   rtag_e              w_rtag_nxt;
   logic               r_last_served;
   logic [STALL_W-1:0] r_stall_cnt;
   logic               w_rd_gnt;
   logic               w_host_gnt;

   // A lock released this cycle already opens arbitration in this same cycle.
   always_comb begin
      w_state_eff = r_state;
      if (r_state == OWN_RD_LOCK && !rd_lock)     w_state_eff = OWN_IDLE;
      if (r_state == OWN_HOST_LOCK && !host_lock) w_state_eff = OWN_IDLE;
   end

   weight_ram_rr_pick u_pick (
      .i_en          (reset),
      .i_rd_req      (rd_req),
      .i_host_req    (host_req),
      .i_state       (w_state_eff),
      .i_last_served (r_last_served),
      .o_rd_gnt      (w_rd_gnt),
      .o_host_gnt    (w_host_gnt)
   );

   always_ff @(posedge clk) begin
      if (!reset) r_state <= OWN_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = w_state_eff;
      w_rtag_nxt  = RTAG_NONE;
      if (w_state_eff == OWN_IDLE) begin
         if (w_rd_gnt && rd_lock)         w_state_nxt = OWN_RD_LOCK;
         else if (w_host_gnt && host_lock) w_state_nxt = OWN_HOST_LOCK;
      end
      if (w_rd_gnt)                     w_rtag_nxt = RTAG_RD;
      else if (w_host_gnt && !host_we)  w_rtag_nxt = RTAG_HOST;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last_served <= PORT_HOST;
         r_rtag        <= RTAG_NONE;
         r_stall_cnt   <= '0;
      end else begin
         r_rtag <= w_rtag_nxt;
         if (w_rd_gnt)        r_last_served <= PORT_RD;
         else if (w_host_gnt) r_last_served <= PORT_HOST;
         if (rd_req && !w_rd_gnt && r_stall_cnt != STALL_MAX)
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
      end
   end

   assign rd_gnt   = w_rd_gnt;
   assign host_gnt = w_host_gnt;
   assign ram_en   = w_rd_gnt | w_host_gnt;
   assign ram_we   = w_host_gnt & host_we;
   assign ram_addr = w_rd_gnt ? rd_addr : (w_host_gnt ? host_addr : '0);
   assign ram_din  = w_host_gnt ? host_wdata : '0;

   assign rd_valid    = (r_rtag == RTAG_RD);
   assign host_rvalid = (r_rtag == RTAG_HOST);
   assign rd_data     = rd_valid ? ram_dout : '0;
   assign host_rdata  = host_rvalid ? ram_dout : '0;

   assign owner        = r_state;
   assign rd_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_weight_ram_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_weight_ram_arbiter;
   import nn_pkg::*;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int SW = 4;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          rd_req, rd_lock, rd_gnt, rd_valid;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          host_req, host_lock, host_we, host_gnt, host_rvalid;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;
   logic [1:0]    owner;
   logic [SW-1:0] rd_stall_cnt;

   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   int checks = 0;
   int failures = 0;

   // Model state: owner 0/1/2, last served 0=RD 1=HOST, pending return tag 0/1/2.
   int            m_owner, m_last, m_tag, m_stall;
   logic [DW-1:0] m_rdata;

   always #5 clk = ~clk;

   weight_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(SW)) dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_lock(rd_lock), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .host_req(host_req), .host_lock(host_lock), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .owner(owner), .rd_stall_cnt(rd_stall_cnt)
   );

   // Single-port RAM with registered read.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_dout <= mem[ram_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int eff_owner();
      int e = m_owner;
      if (e == 1 && !rd_lock)   e = 0;
      if (e == 2 && !host_lock) e = 0;
      return e;
   endfunction

   function automatic void model_grants(output bit g_rd, output bit g_host);
      int e;
      g_rd = 1'b0;
      g_host = 1'b0;
      if (reset !== 1'b1) return;
      e = eff_owner();
      if (e == 1)      g_rd = rd_req;
      else if (e == 2) g_host = host_req;
      else if (rd_req && host_req) begin
         if (m_last == 1) g_rd = 1'b1;
         else             g_host = 1'b1;
      end else begin
         g_rd = rd_req;
         g_host = host_req;
      end
   endfunction

   task automatic cycle(input bit rst_n, input bit rr, input bit rl, input logic [AW-1:0] ra,
                        input bit hr, input bit hl, input bit hw, input logic [AW-1:0] ha,
                        input logic [DW-1:0] hd, input bit late_rst);
      bit g_rd, g_host;
      int e;
      @(negedge clk);
      reset = rst_n; rd_req = rr; rd_lock = rl; rd_addr = ra;
      host_req = hr; host_lock = hl; host_we = hw; host_addr = ha; host_wdata = hd;
      #1;
      check_eq("owner", 32'(owner), 32'(m_owner));
      check_eq("stall_cnt", 32'(rd_stall_cnt), 32'(m_stall));
      check_eq("rd_valid", 32'(rd_valid), 32'(m_tag == 1));
      check_eq("rd_data", 32'(rd_data), 32'((m_tag == 1) ? m_rdata : 8'h00));
      check_eq("host_rvalid", 32'(host_rvalid), 32'(m_tag == 2));
      check_eq("host_rdata", 32'(host_rdata), 32'((m_tag == 2) ? m_rdata : 8'h00));
      model_grants(g_rd, g_host);
      check_eq("rd_gnt", 32'(rd_gnt), 32'(g_rd));
      check_eq("host_gnt", 32'(host_gnt), 32'(g_host));
      check_eq("ram_en", 32'(ram_en), 32'(g_rd | g_host));
      check_eq("ram_we", 32'(ram_we), 32'(g_host & hw));
      check_eq("ram_addr", 32'(ram_addr), 32'(g_rd ? ra : (g_host ? ha : '0)));
      check_eq("ram_din", 32'(ram_din), 32'(g_host ? hd : 8'h00));
      if (late_rst) begin
         reset = 1'b0;
         #1;
         model_grants(g_rd, g_host);
         check_eq("late_rst_gnt", 32'({rd_gnt, host_gnt, ram_en}), 32'(0));
      end
      if (reset !== 1'b1) begin
         m_owner = 0; m_last = 1; m_stall = 0; m_tag = 0;
      end else begin
         e = eff_owner();
         if (rr && !g_rd && m_stall < SMAX) m_stall++;
         m_tag = 0;
         if (g_rd) begin
            m_tag = 1; m_rdata = ref_mem[ra];
         end else if (g_host) begin
            if (hw) ref_mem[ha] = hd;
            else begin m_tag = 2; m_rdata = ref_mem[ha]; end
         end
         if (e == 0) m_owner = (g_rd && rl) ? 1 : ((g_host && hl) ? 2 : 0);
         else        m_owner = e;
         if (g_rd)   m_last = 0;
         if (g_host) m_last = 1;
      end
   endtask

   task automatic idle(input bit rst_n);
      cycle(rst_n, 0, 0, '0, 0, 0, 0, '0, '0, 0);
   endtask

   initial begin
      bit rl_s, hl_s;
      logic [DW-1:0] v;
      for (int i = 0; i < (1 << AW); i++) begin
         v = DW'($urandom);
         mem[i] = v;
         ref_mem[i] = v;
      end
      mem[5] = 8'h3C; ref_mem[5] = 8'h3C;
      reset = 1'b0; rd_req = 0; rd_lock = 0; rd_addr = '0;
      host_req = 0; host_lock = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      repeat (3) @(posedge clk);
      m_owner = 0; m_last = 1; m_tag = 0; m_stall = 0; m_rdata = '0;

      // Reset release with no requests
      idle(1); idle(1);

      // Single RD read of address 5
      cycle(1, 1, 0, 10'h005, 0, 0, 0, '0, '0, 0);
      idle(1);
      check_eq("t2_rd_data", 32'(rd_data), 32'h3C);

      // Both request every cycle: strict alternation starting with RD
      idle(0);
      for (int i = 0; i < 6; i++)
         cycle(1, 1, 0, AW'(i), 1, 0, 0, AW'(i + 8), '0, 0);
      idle(1);
      check_eq("t3_stall", 32'(rd_stall_cnt), 32'd3);

      // RD lock held 8 cycles against a requesting HOST, then dropped
      for (int i = 0; i < 8; i++)
         cycle(1, 1, 1, AW'($urandom_range(0, 15)), 1, 0, 0, 10'h001, '0, 0);
      check_eq("t4_owner_locked", 32'(owner), 32'd1);
      cycle(1, 1, 0, 10'h002, 1, 0, 0, 10'h003, '0, 0);
      check_eq("t4_drop_host_gnt", 32'(host_gnt), 32'd1);
      idle(1);
      check_eq("t4_owner_idle", 32'(owner), 32'd0);

      // HOST locked write, RD blocked, RD reads back after release
      cycle(1, 0, 0, '0, 1, 1, 1, 10'h010, 8'hA5, 0);
      cycle(1, 1, 0, 10'h010, 0, 1, 0, '0, '0, 0);
      check_eq("t5_rd_blocked", 32'(rd_gnt), 32'd0);
      cycle(1, 1, 0, 10'h010, 0, 0, 0, '0, '0, 0);
      idle(1);
      check_eq("t5_rd_data", 32'(rd_data), 32'hA5);

      // Reset arriving behind a granted RD read drops the return
      cycle(1, 1, 0, 10'h020, 0, 0, 0, '0, '0, 1);
      idle(0);
      check_eq("t6_rd_valid", 32'(rd_valid), 32'd0);
      idle(1);
      check_eq("t6_stall", 32'(rd_stall_cnt), 32'd0);

      // Stall counter saturation while HOST holds the lock
      cycle(1, 0, 0, '0, 1, 1, 0, 10'h001, '0, 0);
      for (int i = 0; i < 20; i++)
         cycle(1, 1, 0, 10'h004, 1, 1, 0, AW'($urandom_range(0, 15)), '0, 0);
      idle(1);
      check_eq("t7_stall_sat", 32'(rd_stall_cnt), 32'(SMAX));

      // Random traffic
      idle(0);
      rl_s = 0; hl_s = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) rl_s = ~rl_s;
         if ($urandom_range(0, 5) == 0) hl_s = ~hl_s;
         cycle(($urandom_range(0, 63) != 0),
               ($urandom_range(0, 3) != 0), rl_s, AW'($urandom_range(0, 15)),
               ($urandom_range(0, 2) != 0), hl_s, 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15)), DW'($urandom),
               ($urandom_range(0, 79) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
